// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine front end: channel indices,
// debounce default, coin values and the fixed-priority pick used by the issuer.
package vending_pkg;

    localparam int NUM_CH    = 4;
    localparam int CH_IN1    = 0;
    localparam int CH_IN2    = 1;
    localparam int CH_IN5    = 2;
    localparam int CH_CANCEL = 3;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    localparam int COIN_VAL_IN1 = 1;
    localparam int COIN_VAL_IN2 = 2;
    localparam int COIN_VAL_IN5 = 5;

    typedef logic [NUM_CH-1:0] ch_vec_t;

    // One-hot select of the most urgent request: cancel beats every coin,
    // larger coins beat smaller ones.
    function automatic ch_vec_t pick_highest(input ch_vec_t req);
        ch_vec_t grant;
        grant = '0;
        if (req[CH_CANCEL])
            grant[CH_CANCEL] = 1'b1;
        else if (req[CH_IN5])
            grant[CH_IN5] = 1'b1;
        else if (req[CH_IN2])
            grant[CH_IN2] = 1'b1;
        else if (req[CH_IN1])
            grant[CH_IN1] = 1'b1;
        return grant;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: two-flop synchroniser, stability counter and debounced
// level, producing a single-cycle strobe when the level is accepted as high.
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             at_limit;

    assign at_limit = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Strobe on the same edge that flips the accepted level from 0 to 1.
    assign rise = (sync2 != stable) && at_limit && sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (at_limit) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/coin_debounce.sv
// Conditions the four raw vending inputs into clean, one-hot, single-cycle
// events, queuing at most one accepted press per channel until it is issued.
module coin_debounce
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in1,
    input  logic raw_in2,
    input  logic raw_in5,
    input  logic raw_cancel,
    output logic in1,
    output logic in2,
    output logic in5,
    output logic cancel,
    output logic pending
);

    ch_vec_t raw_vec;
    ch_vec_t rise_vec;
    ch_vec_t pend_q;
    ch_vec_t pend_d;
    ch_vec_t grant;
    ch_vec_t out_q;
    logic    pending_q;

    always_comb begin
        raw_vec            = '0;
        raw_vec[CH_IN1]    = raw_in1;
        raw_vec[CH_IN2]    = raw_in2;
        raw_vec[CH_IN5]    = raw_in5;
        raw_vec[CH_CANCEL] = raw_cancel;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk (clk),
            .rst (rst),
            .raw (raw_vec[g]),
            .rise(rise_vec[g])
        );
    end

    // A fresh rise wins over a same-cycle issue so back-to-back events survive.
    always_comb begin
        grant  = pick_highest(pend_q);
        pend_d = (pend_q & ~grant) | rise_vec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q    <= '0;
            out_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            out_q     <= grant;
            pending_q <= |pend_d;
        end
    end

    assign in1     = out_q[CH_IN1];
    assign in2     = out_q[CH_IN2];
    assign in5     = out_q[CH_IN5];
    assign cancel  = out_q[CH_CANCEL];
    assign pending = pending_q;

endmodule

// File: tb/tb_coin_debounce.sv
// Directed bench for coin_debounce: clean press, bounce, glitch, priority
// ordering, asynchronous reset and an input held through reset.
module tb_coin_debounce;

    logic clk;
    logic rst;
    logic raw_in1;
    logic raw_in2;
    logic raw_in5;
    logic raw_cancel;
    logic in1;
    logic in2;
    logic in5;
    logic cancel;
    logic pending;

    int checks;
    int passes;
    int pulseCnt[4];
    int oneHotErrors;

    coin_debounce dut (
        .clk       (clk),
        .rst       (rst),
        .raw_in1   (raw_in1),
        .raw_in2   (raw_in2),
        .raw_in5   (raw_in5),
        .raw_cancel(raw_cancel),
        .in1       (in1),
        .in2       (in2),
        .in5       (in5),
        .cancel    (cancel),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] outs();
        return {cancel, in5, in2, in1};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed === expected)
            passes++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    endtask

    task automatic clearCounts();
        for (int i = 0; i < 4; i++) pulseCnt[i] = 0;
    endtask

    // One clock: sample 1 ns after the rising edge and tally pulses.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (in1)    pulseCnt[0]++;
            if (in2)    pulseCnt[1]++;
            if (in5)    pulseCnt[2]++;
            if (cancel) pulseCnt[3]++;
            if ((32'(in1) + 32'(in2) + 32'(in5) + 32'(cancel)) > 1) oneHotErrors++;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] raws);
        {raw_cancel, raw_in5, raw_in2, raw_in1} = raws;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        oneHotErrors = 0;
        clearCounts();
        rst = 1'b1;
        applyStimulus(4'b0000);

        tick(2);
        checkOutput("reset_outs", 32'(outs()), 32'h0);
        checkOutput("reset_pending", 32'(pending), 32'h0);
        rst = 1'b0;
        tick(1);
        checkOutput("post_reset_outs", 32'(outs()), 32'h0);
        tick(3);

        // Clean press on in1: pulse follows edge t0+6.
        clearCounts();
        applyStimulus(4'b0001);
        tick(5);
        checkOutput("clean_pend_early", 32'(pending), 32'h0);
        tick(1);
        checkOutput("clean_outs_t5", 32'(outs()), 32'h0);
        checkOutput("clean_pend_t5", 32'(pending), 32'h1);
        tick(1);
        checkOutput("clean_outs_t6", 32'(outs()), 32'h1);
        checkOutput("clean_pend_t6", 32'(pending), 32'h0);
        tick(1);
        checkOutput("clean_outs_t7", 32'(outs()), 32'h0);
        tick(2);
        applyStimulus(4'b0000);
        tick(20);
        checkOutput("clean_in1_count", 32'(pulseCnt[0]), 32'd1);
        checkOutput("clean_other_count", 32'(pulseCnt[1] + pulseCnt[2] + pulseCnt[3]), 32'd0);

        // Bounce on in2, then hold high.
        clearCounts();
        applyStimulus(4'b0010); tick(1);
        applyStimulus(4'b0000); tick(1);
        applyStimulus(4'b0010); tick(1);
        applyStimulus(4'b0000); tick(1);
        applyStimulus(4'b0010);
        tick(6);
        checkOutput("bounce_no_early", 32'(pulseCnt[1]), 32'd0);
        tick(1);
        checkOutput("bounce_outs_t6", 32'(outs()), 32'h2);
        tick(10);
        applyStimulus(4'b0000);
        tick(20);
        checkOutput("bounce_in2_count", 32'(pulseCnt[1]), 32'd1);

        // Short glitch on in5 is filtered.
        clearCounts();
        applyStimulus(4'b0100); tick(2);
        applyStimulus(4'b0000); tick(15);
        checkOutput("glitch_in5_count", 32'(pulseCnt[2]), 32'd0);
        checkOutput("glitch_pending", 32'(pending), 32'h0);

        // Simultaneous in1, in5, cancel: issued cancel, in5, in1.
        clearCounts();
        applyStimulus(4'b1101);
        tick(6);
        checkOutput("simul_outs_t5", 32'(outs()), 32'h0);
        checkOutput("simul_pend_t5", 32'(pending), 32'h1);
        tick(1);
        checkOutput("simul_cancel", 32'(outs()), 32'h8);
        checkOutput("simul_pend_t6", 32'(pending), 32'h1);
        tick(1);
        checkOutput("simul_in5", 32'(outs()), 32'h4);
        checkOutput("simul_pend_t7", 32'(pending), 32'h1);
        tick(1);
        checkOutput("simul_in1", 32'(outs()), 32'h1);
        checkOutput("simul_pend_t8", 32'(pending), 32'h0);
        tick(1);
        checkOutput("simul_after", 32'(outs()), 32'h0);
        applyStimulus(4'b0000);
        tick(20);
        checkOutput("simul_total", 32'(pulseCnt[0] + pulseCnt[1] + pulseCnt[2] + pulseCnt[3]), 32'd3);

        // Asynchronous reset with three events queued.
        clearCounts();
        applyStimulus(4'b1011);
        tick(6);
        checkOutput("midrst_pend_before", 32'(pending), 32'h1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midrst_outs", 32'(outs()), 32'h0);
        checkOutput("midrst_pending", 32'(pending), 32'h0);
        applyStimulus(4'b0000);
        #2;
        rst = 1'b0;
        tick(20);
        checkOutput("midrst_no_pulses", 32'(pulseCnt[0] + pulseCnt[1] + pulseCnt[2] + pulseCnt[3]), 32'd0);

        // Cancel held high through reset counts as a fresh press.
        clearCounts();
        applyStimulus(4'b1000);
        rst = 1'b1;
        tick(3);
        checkOutput("held_in_reset", 32'(outs()), 32'h0);
        rst = 1'b0;
        tick(6);
        checkOutput("held_no_early", 32'(pulseCnt[3]), 32'd0);
        tick(1);
        checkOutput("held_cancel", 32'(outs()), 32'h8);
        tick(25);
        checkOutput("held_cancel_count", 32'(pulseCnt[3]), 32'd1);
        applyStimulus(4'b0000);
        tick(10);

        checkOutput("one_hot", 32'(oneHotErrors), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
